// File: rtl/isc_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
// Optional performance counters are enabled with ISC_PERF_CNT_EN.
package isc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_LDR  = 5'b00001;
    localparam logic [4:0] OP_STR  = 5'b00010;
    localparam logic [4:0] OP_BEQ  = 5'b00011;
    localparam logic [4:0] OP_ADDI = 5'b00100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Defined opcodes are contiguous from OP_R up to OP_ADDI.
    function automatic logic op_legal(input logic [4:0] op);
        return (op <= OP_ADDI);
    endfunction

endpackage

// File: rtl/isc_decode.sv
// Combinational select-line decode from sequencer state and latched opcode.
// Part of instr_seq_ctrl (see ISC_PERF_CNT_EN in the top for counters).
module isc_decode
    import isc_pkg::*;
(
    input  state_e     state_i,
    input  logic [4:0] op_i,
    input  logic [2:0] aluop_i,
    output logic [2:0] alu_signal_o,
    output logic       opb_select_o,
    output logic       r2s_o,
    output logic       mem_we_o,
    output logic       select_mem_o
);

    always_comb begin
        alu_signal_o = ALU_ADD;
        opb_select_o = 1'b0;
        r2s_o        = 1'b0;
        mem_we_o     = 1'b0;
        select_mem_o = 1'b0;

        // MEM keeps the EXEC ALU setup so the address stays stable.
        if (state_i == S_EXEC || state_i == S_MEM) begin
            case (op_i)
                OP_R: begin
                    alu_signal_o = aluop_i;
                    opb_select_o = 1'b0;
                end
                OP_LDR, OP_STR, OP_ADDI: begin
                    alu_signal_o = ALU_ADD;
                    opb_select_o = 1'b1;
                end
                OP_BEQ: begin
                    alu_signal_o = ALU_SUB;
                    opb_select_o = 1'b0;
                end
                default: ;
            endcase
        end

        if (state_i == S_MEM) begin
            select_mem_o = 1'b1;
            mem_we_o     = (op_i == OP_STR);
        end

        if (state_i == S_WB)
            r2s_o = (op_i == OP_LDR);
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory request/ready handshake.
// Define ISC_PERF_CNT_EN to add cycle_count / instr_count outputs.
module instr_seq_ctrl
    import isc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [4:0] opcode,
    input  logic [2:0] aluop,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       select_mem,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_we,
    output logic       r2s,
    output logic       opb_select,
    output logic [2:0] alu_signal,
    output logic       illegal,
    output logic       busy
`ifdef ISC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [2:0] aluop_q, aluop_d;
    logic       illegal_q, illegal_d;
    logic       eoi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_R;
            aluop_q   <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            aluop_q   <= aluop_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        aluop_d   = aluop_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        reg_we    = 1'b0;
        eoi       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                aluop_d = aluop;
                if (op_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_BEQ: begin
                        if (zero) begin
                            pc_we  = 1'b1;
                            pc_src = 1'b1;
                        end
                        eoi = 1'b1;
                    end
                    OP_LDR, OP_STR: state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    if (op_q == OP_LDR)
                        state_d = S_WB;
                    else
                        eoi = 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                eoi    = 1'b1;
            end
            S_TRAP: ;
            default: state_d = S_IDLE;
        endcase

        // run is only looked at between instructions, never mid-instruction.
        if (eoi)
            state_d = run ? S_FETCH : S_IDLE;
    end

    isc_decode u_decode (
        .state_i      (state_q),
        .op_i         (op_q),
        .aluop_i      (aluop_q),
        .alu_signal_o (alu_signal),
        .opb_select_o (opb_select),
        .r2s_o        (r2s),
        .mem_we_o     (mem_we),
        .select_mem_o (select_mem)
    );

    assign illegal = illegal_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_TRAP);

`ifdef ISC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + (busy ? 32'd1 : 32'd0);
        instr_cnt_d = instr_cnt_q + (eoi ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_count = cycle_cnt_q;
    assign instr_count = instr_cnt_q;
`endif

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed per-cycle vector bench for instr_seq_ctrl plus trap/reset corner sequences.
// Counter checks are included when ISC_PERF_CNT_EN is defined.
module tb_instr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, zero, mem_ready;
    logic [4:0] opcode;
    logic [2:0] aluop;
    logic       mem_req, mem_we, select_mem, ir_we, pc_we, pc_src;
    logic       reg_we, r2s, opb_select, illegal, busy;
    logic [2:0] alu_signal;
`ifdef ISC_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    instr_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .aluop      (aluop),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .select_mem (select_mem),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .r2s        (r2s),
        .opb_select (opb_select),
        .alu_signal (alu_signal),
        .illegal    (illegal),
        .busy       (busy)
`ifdef ISC_PERF_CNT_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Output vector: {mem_req, mem_we, select_mem, ir_we, pc_we, pc_src,
    //                 reg_we, r2s, opb_select, alu_signal[2:0], illegal, busy}
    function automatic logic [13:0] outs();
        return {mem_req, mem_we, select_mem, ir_we, pc_we, pc_src,
                reg_we, r2s, opb_select, alu_signal, illegal, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic        run;
        logic [4:0]  op;
        logic [2:0]  aluop;
        logic        zero;
        logic        mr;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [4:0] o, input logic [2:0] a,
                                input logic z, input logic m, input logic [13:0] e);
        vec_t v;
        v.run = r; v.op = o; v.aluop = a; v.zero = z; v.mr = m; v.exp = e;
        return v;
    endfunction

    localparam logic [13:0] E_IDLE  = 14'b0_0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [13:0] E_FETCH = 14'b1_0_0_1_1_0_0_0_0_000_0_1;
    localparam logic [13:0] E_FWAIT = 14'b1_0_0_0_0_0_0_0_0_000_0_1;
    localparam logic [13:0] E_BUSY  = 14'b0_0_0_0_0_0_0_0_0_000_0_1;
    localparam logic [13:0] E_EXIMM = 14'b0_0_0_0_0_0_0_0_1_000_0_1;
    localparam logic [13:0] E_WBALU = 14'b0_0_0_0_0_0_1_0_0_000_0_1;

    initial begin
        // ADDI, all-ready memory; opcode input scrambled after DECODE
        vecs.push_back(mk(1, 5'b00000, 3'b000, 0, 0, E_IDLE));
        vecs.push_back(mk(1, 5'b00100, 3'b000, 0, 1, E_FETCH));
        vecs.push_back(mk(1, 5'b00100, 3'b000, 0, 1, E_BUSY));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 1, E_EXIMM));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 1, E_WBALU));
        // LDR with two wait cycles in MEM
        vecs.push_back(mk(1, 5'b00000, 3'b000, 0, 1, E_FETCH));
        vecs.push_back(mk(1, 5'b00001, 3'b000, 0, 1, E_BUSY));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 0, E_EXIMM));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 0, 14'b1_0_1_0_0_0_0_0_1_000_0_1));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 0, 14'b1_0_1_0_0_0_0_0_1_000_0_1));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 1, 14'b1_0_1_0_0_0_0_0_1_000_0_1));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 0, 14'b0_0_0_0_0_0_1_1_0_000_0_1));
        // BEQ taken
        vecs.push_back(mk(1, 5'b00000, 3'b000, 0, 1, E_FETCH));
        vecs.push_back(mk(1, 5'b00011, 3'b000, 0, 1, E_BUSY));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 1, 1, 14'b0_0_0_0_1_1_0_0_0_001_0_1));
        // BEQ not taken
        vecs.push_back(mk(1, 5'b00000, 3'b000, 0, 1, E_FETCH));
        vecs.push_back(mk(1, 5'b00011, 3'b000, 0, 1, E_BUSY));
        vecs.push_back(mk(1, 5'b11111, 3'b000, 0, 1, 14'b0_0_0_0_0_0_0_0_0_001_0_1));
        // R-type aluop=101, one fetch wait cycle; aluop input changed after DECODE
        vecs.push_back(mk(1, 5'b00000, 3'b000, 0, 0, E_FWAIT));
        vecs.push_back(mk(1, 5'b00000, 3'b000, 0, 1, E_FETCH));
        vecs.push_back(mk(1, 5'b00000, 3'b101, 0, 1, E_BUSY));
        vecs.push_back(mk(1, 5'b11111, 3'b010, 0, 1, 14'b0_0_0_0_0_0_0_0_0_101_0_1));
        vecs.push_back(mk(1, 5'b11111, 3'b010, 0, 1, E_WBALU));
        // STR with run dropped mid-instruction; ends in IDLE
        vecs.push_back(mk(0, 5'b00000, 3'b000, 0, 1, E_FETCH));
        vecs.push_back(mk(0, 5'b00010, 3'b000, 0, 1, E_BUSY));
        vecs.push_back(mk(0, 5'b11111, 3'b000, 0, 1, E_EXIMM));
        vecs.push_back(mk(0, 5'b11111, 3'b000, 0, 1, 14'b1_1_1_0_0_0_0_0_1_000_0_1));
        vecs.push_back(mk(0, 5'b11111, 3'b000, 0, 1, E_IDLE));
        vecs.push_back(mk(0, 5'b11111, 3'b000, 0, 1, E_IDLE));

        rst = 1'b1; run = 1'b0; opcode = 5'b0; aluop = 3'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {18'b0, outs()}, {18'b0, E_IDLE});
`ifdef ISC_PERF_CNT_EN
        chk("reset_cycle_count", cycle_count, 32'd0);
        chk("reset_instr_count", instr_count, 32'd0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run; opcode = vecs[i].op; aluop = vecs[i].aluop;
            zero = vecs[i].zero; mem_ready = vecs[i].mr;
            #1;
            chk($sformatf("vec%0d", i), {18'b0, outs()}, {18'b0, vecs[i].exp});
        end
`ifdef ISC_PERF_CNT_EN
        chk("table_cycle_count", cycle_count, 32'd26);
        chk("table_instr_count", instr_count, 32'd6);
`endif

        // Illegal opcode traps and stays there until reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 5'b00000;
        @(negedge clk);
        @(negedge clk); opcode = 5'b11111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            chk($sformatf("trap%0d", k), {18'b0, outs()}, {18'b0, 14'b0_0_0_0_0_0_0_0_0_000_1_0});
        end
        rst = 1'b1; #1;
        chk("trap_rst_clears", {18'b0, outs()}, {18'b0, E_IDLE});

        // Reset asserted while fetch request is outstanding
        @(negedge clk); rst = 1'b0; run = 1'b1; mem_ready = 1'b0; opcode = 5'b00000;
        @(negedge clk); #1;
        chk("fetch_req_up", {31'b0, mem_req}, 32'd1);
        rst = 1'b1; #1;
        chk("rst_mid_fetch", {18'b0, outs()}, {18'b0, E_IDLE});
        @(negedge clk); rst = 1'b0; run = 1'b0;
        @(negedge clk); #1;
        chk("idle_after_rst", {30'b0, busy, mem_req}, 32'd0);

`ifdef ISC_PERF_CNT_EN
        // Three R-types back to back; run dropped during the third
        rst = 1'b1; #1;
        chk("perf_rst_cycle", cycle_count, 32'd0);
        chk("perf_rst_instr", instr_count, 32'd0);
        @(negedge clk); rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 5'b00000;
        repeat (9) @(negedge clk);
        run = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("perf_instr3", instr_count, 32'd3);
        chk("perf_cycle12", cycle_count, 32'd12);
        chk("perf_idle", {31'b0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
